// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family.
//   BCD_MAX / BCD_MIN : legal digit bounds
//   bcd_t             : one 4-bit BCD digit
//   bcd_clamp()       : maps non-BCD codes (10..15) onto 9
package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam bcd_t BCD_MIN = 4'd0;

  function automatic bcd_t bcd_clamp(input logic [3:0] d);
    return (d > BCD_MAX) ? BCD_MAX : bcd_t'(d);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit with load, up/down count and combinational carry/borrow out.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   en    : count this edge (already includes carry-in from lower digits)
//   up    : 1 = increment, 0 = decrement
//   load  : load clamped d, overrides en
//   d     : digit to load (may be non-BCD)
//   q     : current digit, always 0..9
//   co    : carry (up) / borrow (down) into the next digit this cycle
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] d,
  output bcd_t       q,
  output logic       co
);

  bcd_t q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = bcd_clamp(d);
    end else if (en) begin
      if (up) begin
        q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
      end else begin
        q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= BCD_MIN;
    end else begin
      q_q <= q_d;
    end
  end

  assign q  = q_q;
  // Gated by en so the enable chain ripples only while lower digits roll over.
  assign co = en & (up ? (q_q == BCD_MAX) : (q_q == BCD_MIN));

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with sanitising parallel load and wrap/saturate.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   x        : count enable
//   up       : 1 = increment, 0 = decrement
//   sat      : 0 = wrap at limits, 1 = saturate at limits
//   load     : synchronous parallel load (wins over x)
//   load_val : BCD value to load, digit i at [4i+3:4i]; digits >9 clamp to 9
//   out      : current count, BCD
//   tc       : registered pulse on every wrap or blocked-at-limit count
//   load_err : registered pulse when the last load clamped any digit
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned SAT_DEFAULT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                x,
  input  logic                up,
  input  logic                sat,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] out,
  output logic                tc,
  output logic                load_err
);

  if (DIGITS < 1 || DIGITS > 8 || SAT_DEFAULT > 1) begin : g_param_check
    $error("bcd_counter_n: DIGITS must be 1..8 and SAT_DEFAULT 0 or 1");
  end

  logic [DIGITS-1:0] co;
  logic [DIGITS-1:0] dig_en;
  logic              at_max, at_min, limit_hit, bad_digit, cnt_en;
  logic              tc_d, tc_q, load_err_d, load_err_q;

  always_comb begin
    at_max    = 1'b1;
    at_min    = 1'b1;
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      at_max    = at_max & (out[4*i +: 4] == BCD_MAX);
      at_min    = at_min & (out[4*i +: 4] == BCD_MIN);
      bad_digit = bad_digit | (load_val[4*i +: 4] > BCD_MAX);
    end
  end

  // A count at the limit in the current direction either wraps or is blocked.
  assign limit_hit = up ? at_max : at_min;
  assign cnt_en    = x & ~load & ~(sat & limit_hit);

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign dig_en[i] = cnt_en;
    end else begin : g_upper
      assign dig_en[i] = cnt_en & co[i-1];
    end

    bcd_digit u_digit (
      .clk   (clk),
      .reset (reset),
      .en    (dig_en[i]),
      .up    (up),
      .load  (load),
      .d     (load_val[4*i +: 4]),
      .q     (out[4*i +: 4]),
      .co    (co[i])
    );
  end

  always_comb begin
    tc_d       = x & ~load & limit_hit;
    load_err_d = load & bad_digit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tc_q       <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      tc_q       <= tc_d;
      load_err_q <= load_err_d;
    end
  end

  assign tc       = tc_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
`timescale 1ns/1ps
module tb_bcd_counter_n;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        x = 1'b0, up = 1'b1, sat = 1'b0, load = 1'b0;
  logic [31:0] load_val = '0;
  logic [7:0]  out2;
  logic [15:0] out4;
  logic        tc2, tc4, err2, err4;

  always #5 clk = ~clk;

  bcd_counter_n #(.DIGITS(2), .SAT_DEFAULT(0)) u_dut2 (
    .clk(clk), .reset(reset), .x(x), .up(up), .sat(sat), .load(load),
    .load_val(load_val[7:0]), .out(out2), .tc(tc2), .load_err(err2)
  );

  bcd_counter_n #(.DIGITS(4), .SAT_DEFAULT(0)) u_dut4 (
    .clk(clk), .reset(reset), .x(x), .up(up), .sat(sat), .load(load),
    .load_val(load_val[15:0]), .out(out4), .tc(tc4), .load_err(err4)
  );

  typedef struct packed {
    logic [15:0] o4;
    logic [7:0]  o2;
    logic        tc4, tc2, e4, e2;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m2 = 0, m4 = 0;  // reference counts as plain integers

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] int2bcd(input int v, input int nd);
    logic [31:0] r = '0;
    int t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Reference: integer count modulo 10**nd; loads clamp each digit to 9.
  task automatic model(input int nd, inout int v, input logic xx, input logic uu,
                       input logic ss, input logic ll, input logic [31:0] lv,
                       output logic tc_o, output logic err_o);
    int maxv = 1;
    for (int i = 0; i < nd; i++) maxv = maxv * 10;
    maxv = maxv - 1;
    tc_o  = 1'b0;
    err_o = 1'b0;
    if (ll) begin
      int acc = 0;
      for (int i = nd - 1; i >= 0; i--) begin
        int dg = int'(lv[4*i +: 4]);
        if (dg > 9) begin
          dg = 9;
          err_o = 1'b1;
        end
        acc = acc * 10 + dg;
      end
      v = acc;
    end else if (xx) begin
      if (uu) begin
        if (v == maxv) begin
          tc_o = 1'b1;
          if (!ss) v = 0;
        end else v = v + 1;
      end else begin
        if (v == 0) begin
          tc_o = 1'b1;
          if (!ss) v = maxv;
        end else v = v - 1;
      end
    end
  endtask

  task automatic cyc(input logic xx, input logic uu, input logic ss, input logic ll,
                     input logic [31:0] lv);
    exp_t e;
    logic t2, t4, f2, f4;
    @(negedge clk);
    x = xx; up = uu; sat = ss; load = ll; load_val = lv;
    model(2, m2, xx, uu, ss, ll, lv, t2, f2);
    model(4, m4, xx, uu, ss, ll, lv, t4, f4);
    e.o2 = 8'(int2bcd(m2, 2));
    e.o4 = 16'(int2bcd(m4, 4));
    e.tc2 = t2; e.tc4 = t4; e.e2 = f2; e.e4 = f4;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is one DUT response.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out2", 32'(out2), 32'(e.o2));
        check("tc2", 32'(tc2), 32'(e.tc2));
        check("load_err2", 32'(err2), 32'(e.e2));
        check("out4", 32'(out4), 32'(e.o4));
        check("tc4", 32'(tc4), 32'(e.tc4));
        check("load_err4", 32'(err4), 32'(e.e4));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #20;
    check("reset_out2", 32'(out2), 32'h0);
    check("reset_out4", 32'(out4), 32'h0);
    check("reset_flags", 32'({tc2, err2, tc4, err4}), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Count up from reset.
    for (int i = 0; i < 12; i++) cyc(1, 1, 0, 0, 0);
    // Up wrap.
    cyc(0, 1, 0, 1, 32'h9998);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    // Down wrap with borrow.
    cyc(0, 0, 0, 1, 32'h0010);
    for (int i = 0; i < 11; i++) cyc(1, 0, 0, 0, 0);
    // Saturate at top, then step down.
    cyc(0, 1, 1, 1, 32'h9999);
    for (int i = 0; i < 3; i++) cyc(1, 1, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    // Saturate at bottom.
    cyc(0, 0, 1, 1, 32'h0000);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    // Load sanitise and priority over x.
    cyc(1, 1, 0, 1, 32'hA3A3);
    cyc(1, 1, 0, 1, 32'h0042);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // Four-digit wrap.
    cyc(0, 1, 0, 1, 32'h9999);
    cyc(1, 1, 0, 0, 0);

    // Randomised mix.
    for (int i = 0; i < 500; i++) begin
      logic [31:0] lv = $urandom;
      cyc(($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) == 0), lv);
    end

    // Async reset mid-count.
    cyc(0, 1, 0, 1, 32'h0056);
    cyc(1, 1, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_out2", 32'(out2), 32'h0);
    check("async_out4", 32'(out4), 32'h0);
    check("async_flags", 32'({tc2, err2, tc4, err4}), 32'h0);
    @(posedge clk);
    #1;
    check("held_out2", 32'(out2), 32'h0);
    check("held_out4", 32'(out4), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    x = 1'b0;
    load = 1'b0;
    m2 = 0;
    m4 = 0;
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0, 0);

    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_counter_n.md
# bcd_counter_n

Parametrised N-digit BCD counter, the successor to the fixed two-digit BCD counter. It adds up/down counting, a synchronous parallel load with digit sanitising, and a wrap or saturate mode. It also registers a terminal-count event for cascading into display and timer logic. Counting is gated per clock by the enable input `x`, as in the two-digit block.

## Interface

Parameters:
- DIGITS, default 4: number of BCD digits; legal range 1..8.
- SAT_DEFAULT, default 0: reserved; `sat` port governs mode at run time (kept for synthesis-time tie-off tools).

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- x  input  1  count enable, sampled on rising `clk`.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  mode: 0 = wrap-around, 1 = saturate at limits.
- load  input  1  synchronous parallel load request.
- load_val  input  4*DIGITS  BCD value to load; digit i at bits [4i+3:4i].
- out  output  4*DIGITS  current count, BCD; digit 0 least significant.
- tc  output  1  registered terminal-count event pulse.
- load_err  output  1  registered pulse: last load contained a non-BCD digit.

## Operation

- Reset (reset=0, async): out=0, tc=0, load_err=0 immediately; held while reset low.
- Priority per edge: load > count (x) > hold.
- Load: each digit of load_val >9 (10..15) is clamped to 9; out <= sanitised value.
  - load_err=1 for one cycle if any digit clamped, else 0.
  - tc=0 on a load cycle; x ignored.
- Count (x=1, load=0):
  - up=1: digit 0 increments; a digit at 9 goes to 0 and carries into the next digit.
  - up=0: digit 0 decrements; a digit at 0 goes to 9 and borrows from the next digit.
  - Upper limit is all digits 9 (e.g. 99 for DIGITS=2); lower limit is 0.
  - sat=0 (wrap): upper limit +1 -> 0; 0 -1 -> upper limit; tc=1 for that cycle.
  - sat=1 (saturate): at upper limit with up=1, or at 0 with up=0, out holds; tc=1 every such blocked cycle.
- Hold (x=0, load=0): out unchanged; tc=0, load_err=0.
- Internal digit states are never outside 0..9, including after any load.
- `up` and `sat` are sampled each edge; changing either mid-count has effect from the next edge only.

## Timing

- Latency: out reflects a count or load on the same rising edge that samples x/load (1-cycle registered).
- tc and load_err are registered and coincident with the out value they describe; each is high for exactly one cycle per event.
- Consecutive wrap or saturate events keep tc high on consecutive cycles.
- Reset assertion mid-count clears all outputs asynchronously, with no glitch to intermediate values afterwards.
- Reset deassertion is synchronised by the system; first count occurs on the first edge with reset=1 and x=1.
- The carry chain is combinational across all digits within one cycle; DIGITS<=8 must close timing at the system clock.

## Structure

- Shared package `bcd_pkg`:
  - constants BCD_MAX=4'd9 and BCD_MIN=4'd0;
  - typedef for a 4-bit BCD digit;
  - function `bcd_clamp` (digit >9 -> 9).
- One sub-module `bcd_digit`, instantiated DIGITS times via generate:
  - inputs: clk, reset, en, up, load, d;
  - outputs: q, co (carry/borrow out to the next digit, combinational);
  - en of digit i = x AND co of digit i-1.
- Top level handles:
  - limit detection (all-9 / all-0), gating en to 0 in saturate mode;
  - tc and load_err registers.

## Test plan

All scenarios use DIGITS=2 unless noted.

- Reset then count: reset low 20 ns, release; x=1, up=1 for 12 cycles -> out 00,01,…,09,10,11,12; tc stays 0.
- Up wrap: load 8'h98, then x=1, up=1 for 2 cycles -> out 99 then 00; tc=1 only on the 00 cycle.
- Down wrap and borrow: load 8'h10, up=0, x=1 -> out 09; after 9 more cycles 00, next 99 with tc=1.
- Saturate: sat=1, load 8'h99, up=1, x=1 for 3 cycles -> out stays 99, tc=1 all 3 cycles; up=0 -> 98 with tc=0.
- Load sanitise and priority: load=1, x=1, load_val=8'hA3 -> out 93, load_err=1 for one cycle, no count that edge; load_val=8'h42 -> out 42, load_err=0.
- Async reset mid-count: out at 57 counting; reset low between edges -> out 00, tc 0 immediately; out holds 00 until reset=1; DIGITS=4 rerun: load 16'h9999, count up -> 0000 with tc=1.
